vector_scalar_divider: RTL and testbench
========================================

// Module: vector_scalar_divider
// PURPOSE
//  Divides each component of a packed 3x32 signed fixed-point vector by one signed scalar: r = v / s.
//  Inverse counterpart to the vector scaling/doubling arithmetic. Used for ray-direction scaling and reciprocal normalisation.
//  Iterative restoring division, one quotient bit per clock. Three component dividers run in parallel.
//  valid/ready handshake on both input and output.
// PARAMETERS
//  FRAC_BITS  16  fractional bits of the signed fixed-point format (Q(31-FRAC_BITS).FRAC_BITS); QW = 32+FRAC_BITS
// PORTS
//  clk           input   1   clock, all state on rising edge
//  rst           input   1   synchronous, active-high reset
//  in_valid      input   1   v/s valid
//  in_ready      output  1   block can accept an operation
//  v             input   96  vector; component i = v[32*i+:32], signed fixed-point
//  s             input   32  signed fixed-point divisor
//  out_valid     output  1   r valid
//  out_ready     input   1   consumer accepts r
//  r             output  96  quotient vector, component i = r[32*i+:32]
//  div_by_zero   output  1   qualifies r: s was 0
// BEHAVIOUR
//  Reset (rst=1 at clock edge): state=IDLE; out_valid=0, div_by_zero=0, r=0; in_ready=0 while rst high.
//  Reset mid-operation: aborts, result discarded, no out_valid pulse.
//  States:
//   IDLE: in_ready=(~rst). On in_valid&in_ready, latch operands:
//    s==0 -> DONE; else -> DIV with bit counter=QW-1.
//   DIV: one quotient bit per clock for QW clocks.
//    After the QW-th DIV clock -> DONE.
//    out_valid rises exactly QW clocks (48 at default) after the accepting edge.
//   DONE: out_valid=1.
//    r and div_by_zero held stable until out_valid&out_ready, then -> IDLE.
//    in_ready=0 in DIV and DONE: no accept in the same cycle as an output transfer.
//    Next accept is possible one cycle after the transfer.
//  Arithmetic, per component:
//   Sign: neg = v[31]^s[31].
//   Operands: 32-bit unsigned magnitudes |v|, |s|; |-2^31| = 2^31 is representable.
//   Dividend: |v| << FRAC_BITS (QW bits); restoring division by |s| gives a QW-bit quotient magnitude q.
//   Rounding: truncate toward zero.
//   Saturation: if !neg and q >= 2^31 -> 0x7FFFFFFF; if neg and q >= 2^31 -> 0x80000000; otherwise r = neg ? -q : q.
//   Zero quotient is always 0x00000000, never negative zero or 0x80000000.
//  Divide by zero (s==0):
//   r component = 0x7FFFFFFF if v>0, 0x80000000 if v<0, 0x00000000 if v==0; div_by_zero=1.
//   out_valid rises 1 clock after the accepting edge.
//  div_by_zero=0 for every nonzero s.
//  Output registers only change on entry to DONE or on reset.
// TESTING
//  1 v=(0x00020000,0xFFFD0000,0x00008000), s=0x00020000 -> r=(0x00010000,0xFFFE8000,0x00004000).
//    out_valid exactly 48 clocks after accept; div_by_zero=0.
//  2 v=(0x7FFF0000,0x00010000,0xFFFF0000), s=0x00000100 -> r=(0x7FFFFFFF,0x01000000,0xFF000000). Positive saturation.
//  3 v=(0x00000001,0xFFFFFFFF,0x80000000), s=0x00030000 -> r=(0x00000000,0x00000000,0xD5555556). Truncation toward zero, -2^31 operand.
//  4 v=(0x00050000,0xFFFB0000,0), s=0 -> r=(0x7FFFFFFF,0x80000000,0x00000000), div_by_zero=1.
//    out_valid 1 clock after accept.
//  5 Op 1 with out_ready=0 for 10 cycles -> r stable, in_ready=0, held in_valid ignored.
//    out_ready=1 -> one transfer; in_ready=1 next cycle; queued op then completes correctly.
//  6 rst=1 for one cycle, 20 clocks into DIV -> no out_valid; in_ready=1 the cycle after rst falls.
//    Fresh op 1 then returns the correct r.

Source files
------------

// File: rtl/vector_scalar_divider.sv
// Divides each component of a packed 3x32 signed fixed-point vector by one signed scalar.
// Three restoring dividers share a bit counter and produce one quotient bit per clock.
module vector_scalar_divider #(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] v,
    input  logic [31:0] s,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] r,
    output logic        div_by_zero
);

    localparam int QW = 32 + FRAC_BITS;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     div_q, div_d;
    logic [QW-1:0]   dq_q  [3];
    logic [QW-1:0]   dq_d  [3];
    logic [31:0]     rem_q [3];
    logic [31:0]     rem_d [3];
    logic [2:0]      neg_q, neg_d;
    logic [2:0]      vneg_q, vneg_d;
    logic [2:0]      vnz_q, vnz_d;
    logic            out_valid_q, out_valid_d;
    logic [95:0]     r_q, r_d;
    logic            dbz_q, dbz_d;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        if (x[31]) begin
            abs32 = 32'd0 - x;
        end else begin
            abs32 = x;
        end
    endfunction

    // One restoring step: the dividend shifts out of dq's top while quotient bits enter its bottom.
    function automatic logic [QW+31:0] div_step(input logic [31:0] rem,
                                                input logic [QW-1:0] dq,
                                                input logic [31:0] d);
        logic [32:0] trial;
        trial = {rem, dq[QW-1]};
        if (trial >= {1'b0, d}) begin
            div_step = {trial[31:0] - d, dq[QW-2:0], 1'b1};
        end else begin
            div_step = {trial[31:0], dq[QW-2:0], 1'b0};
        end
    endfunction

    function automatic logic [31:0] finalize(input logic [QW-1:0] q, input logic neg);
        if (q[QW-1:31] != {(QW-31){1'b0}}) begin
            finalize = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (neg) begin
            finalize = 32'd0 - q[31:0];
        end else begin
            finalize = q[31:0];
        end
    endfunction

    function automatic logic [31:0] dbz_value(input logic is_neg, input logic is_nz);
        if (!is_nz) begin
            dbz_value = 32'h0000_0000;
        end else if (is_neg) begin
            dbz_value = 32'h8000_0000;
        end else begin
            dbz_value = 32'h7FFF_FFFF;
        end
    endfunction

    assign in_ready    = (state_q == IDLE) && !rst;
    assign out_valid   = out_valid_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;

    // Next-state, datapath step and output-register loads.
    always_comb begin
        logic [QW+31:0] step;
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        neg_d       = neg_q;
        vneg_d      = vneg_q;
        vnz_d       = vnz_q;
        out_valid_d = out_valid_q;
        r_d         = r_q;
        dbz_d       = dbz_q;
        step        = {(QW+32){1'b0}};
        for (int i = 0; i < 3; i++) begin
            dq_d[i]  = dq_q[i];
            rem_d[i] = rem_q[i];
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    div_d = abs32(s);
                    cnt_d = CW'(QW - 1);
                    for (int i = 0; i < 3; i++) begin
                        dq_d[i]   = {abs32(v[32*i +: 32]), {FRAC_BITS{1'b0}}};
                        rem_d[i]  = 32'd0;
                        neg_d[i]  = v[32*i + 31] ^ s[31];
                        vneg_d[i] = v[32*i + 31];
                        vnz_d[i]  = (v[32*i +: 32] != 32'd0);
                    end
                    state_d = (s == 32'd0) ? DONE : DIV;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                for (int i = 0; i < 3; i++) begin
                    step     = div_step(rem_q[i], dq_q[i], div_q);
                    rem_d[i] = step[QW+31:QW];
                    dq_d[i]  = step[QW-1:0];
                    if (cnt_q == {CW{1'b0}}) begin
                        r_d[32*i +: 32] = finalize(step[QW-1:0], neg_q[i]);
                    end else begin
                        r_d[32*i +: 32] = r_q[32*i +: 32];
                    end
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    dbz_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                // A zero divisor enters DONE straight from IDLE; its result loads on the first DONE clock.
                if (!out_valid_q) begin
                    for (int i = 0; i < 3; i++) begin
                        r_d[32*i +: 32] = dbz_value(vneg_q[i], vnz_q[i]);
                    end
                    out_valid_d = 1'b1;
                    dbz_d       = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            div_q       <= 32'd0;
            neg_q       <= 3'd0;
            vneg_q      <= 3'd0;
            vnz_q       <= 3'd0;
            out_valid_q <= 1'b0;
            r_q         <= 96'd0;
            dbz_q       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                dq_q[i]  <= {QW{1'b0}};
                rem_q[i] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            neg_q       <= neg_d;
            vneg_q      <= vneg_d;
            vnz_q       <= vnz_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            dbz_q       <= dbz_d;
            for (int i = 0; i < 3; i++) begin
                dq_q[i]  <= dq_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_vector_scalar_divider.sv
// Scoreboard bench for vector_scalar_divider: expectations are queued on accept
// from an arithmetic reference model and checked by an independent output monitor.
module tb_vector_scalar_divider;

    localparam int FRAC = 16;
    localparam int QW   = 32 + FRAC;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] v;
    logic [31:0] s;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] r;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit seen   = 1'b0;

    typedef struct {
        logic [95:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    vector_scalar_divider #(.FRAC_BITS(FRAC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .v          (v),
        .s          (s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .r          (r),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: exact signed quotient, truncated toward zero, clamped to the 32-bit range.
    function automatic logic [31:0] model_comp(input logic [31:0] vc, input logic [31:0] sc);
        longint a, b, q;
        a = longint'($signed(vc));
        b = longint'($signed(sc));
        if (b == 0) begin
            if (a > 0) return 32'h7FFF_FFFF;
            if (a < 0) return 32'h8000_0000;
            return 32'h0000_0000;
        end
        q = (a * (longint'(1) << FRAC)) / b;
        if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (q < -64'sd2147483648) return 32'h8000_0000;
        return q[31:0];
    endfunction

    function automatic logic [95:0] model_vec(input logic [95:0] vv, input logic [31:0] ss);
        logic [95:0] res;
        for (int i = 0; i < 3; i++) res[32*i +: 32] = model_comp(vv[32*i +: 32], ss);
        return res;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Push the expected response whenever the DUT is about to accept an operation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e.r   = model_vec(v, s);
            e.dbz = (s == 32'd0);
            e.lat = (s == 32'd0) ? 1 : QW;
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
        end
    end

    // Monitor: latency on the rising out_valid, data on each transfer.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {95'd0, out_valid}, 96'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", 96'(cyc - acc_q[0]), 96'(exp_q[0].lat));
                end
                if (out_ready) begin
                    check("r", r, exp_q[0].r);
                    check("div_by_zero", {95'd0, div_by_zero}, {95'd0, exp_q[0].dbz});
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [95:0] vv, input logic [31:0] ss);
        bit ok = 1'b0;
        v = vv;
        s = ss;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 96'd0, 96'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        bit ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        if (!ok) check("done_timeout", 96'd0, 96'd1);
    endtask

    task automatic wait_out_valid();
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("out_valid_timeout", 96'd0, 96'd1);
    endtask

    task automatic directed(input string name, input logic [95:0] vv, input logic [31:0] ss,
                            input logic [95:0] exp_r);
        issue(vv, ss);
        wait_out_valid();
        check(name, r, exp_r);
        wait_done(1'b0);
    endtask

    localparam logic [95:0] V1 = {32'h0000_8000, 32'hFFFD_0000, 32'h0002_0000};
    localparam logic [95:0] R1 = {32'h0000_4000, 32'hFFFE_8000, 32'h0001_0000};
    localparam logic [95:0] V5 = {32'h0000_0000, 32'h0003_0000, 32'hFFF0_0000};

    initial begin
        logic [95:0] rv;
        logic [31:0] rs;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        v = 96'd0;
        s = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", {95'd0, in_ready}, 96'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {95'd0, out_valid}, 96'd0);
        check("reset_r", r, 96'd0);
        check("reset_dbz", {95'd0, div_by_zero}, 96'd0);
        check("reset_in_ready", {95'd0, in_ready}, 96'd1);
        @(posedge clk);
        #1;

        directed("t1_r", V1, 32'h0002_0000, R1);
        directed("t2_r", {32'hFFFF_0000, 32'h0001_0000, 32'h7FFF_0000}, 32'h0000_0100,
                 {32'hFF00_0000, 32'h0100_0000, 32'h7FFF_FFFF});
        directed("t3_r", {32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001}, 32'h0003_0000,
                 {32'hD555_5556, 32'h0000_0000, 32'h0000_0000});
        directed("t4_r", {32'h0000_0000, 32'hFFFB_0000, 32'h0005_0000}, 32'h0000_0000,
                 {32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF});

        // Back-pressure: result held, second operation waits on in_valid.
        out_ready = 1'b0;
        issue(V1, 32'h0002_0000);
        v = V5;
        s = 32'hFFFF_0000;
        in_valid = 1'b1;
        wait_out_valid();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_r", r, R1);
            check("hold_in_ready", {95'd0, in_ready}, 96'd0);
            check("hold_out_valid", {95'd0, out_valid}, 96'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("in_ready_after_xfer", {95'd0, in_ready}, 96'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(1'b0);

        // Reset in the middle of a division.
        issue(V1, 32'h0002_0000);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("in_ready_after_rst", {95'd0, in_ready}, 96'd1);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) check("no_out_after_rst", {95'd0, out_valid}, 96'd0);
        end
        @(posedge clk);
        #1;
        directed("t6_r", V1, 32'h0002_0000, R1);

        // Randomised operands and consumer back-pressure.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 3))
                    0: rv[32*i +: 32] = $urandom >> $urandom_range(8, 31);
                    1: rv[32*i +: 32] = 32'd0 - ($urandom >> $urandom_range(8, 31));
                    2: begin
                        case ($urandom_range(0, 2))
                            0: rv[32*i +: 32] = 32'h8000_0000;
                            1: rv[32*i +: 32] = 32'h7FFF_FFFF;
                            default: rv[32*i +: 32] = 32'h0000_0000;
                        endcase
                    end
                    default: rv[32*i +: 32] = $urandom;
                endcase
            end
            if ($urandom_range(0, 7) == 0) begin
                rs = 32'd0;
            end else begin
                rs = $urandom >> $urandom_range(0, 30);
                if (rs == 32'd0) rs = 32'd1;
                if ($urandom_range(0, 1) == 1) rs = 32'd0 - rs;
            end
            issue(rv, rs);
            wait_done(1'b1);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
